// File: rtl/onchip_mem_arbiter.sv
// Two-master Avalon-MM arbiter for the single-port on-chip RAM: m1 (sample capture) has
// priority, bounded by MAX_HOLD so the Nios data master is never starved.
module onchip_mem_arbiter #(
    parameter int unsigned ADDR_W   = 15,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_HOLD = 4,
    parameter int unsigned STALL_W  = 16,
    localparam int unsigned BE_W    = DATA_W / 8
) (
    input  logic               clk,
    input  logic               reset_n,

    input  logic [ADDR_W-1:0]  m0_address,
    input  logic               m0_read,
    input  logic               m0_write,
    input  logic [BE_W-1:0]    m0_byteenable,
    input  logic [DATA_W-1:0]  m0_writedata,
    output logic               m0_waitrequest,
    output logic [DATA_W-1:0]  m0_readdata,
    output logic               m0_readdatavalid,

    input  logic [ADDR_W-1:0]  m1_address,
    input  logic               m1_read,
    input  logic               m1_write,
    input  logic [BE_W-1:0]    m1_byteenable,
    input  logic [DATA_W-1:0]  m1_writedata,
    output logic               m1_waitrequest,
    output logic [DATA_W-1:0]  m1_readdata,
    output logic               m1_readdatavalid,

    output logic [ADDR_W-1:0]  mem_address,
    output logic [BE_W-1:0]    mem_byteenable,
    output logic               mem_chipselect,
    output logic               mem_write,
    output logic [DATA_W-1:0]  mem_writedata,
    output logic               mem_clken,
    input  logic [DATA_W-1:0]  mem_readdata,

    output logic [STALL_W-1:0] m0_stall_count
);

    localparam int unsigned HOLD_W = 4;

    logic              req0;
    logic              req1;
    logic              gnt0;
    logic              gnt1;
    logic              hold_max;
    logic [HOLD_W-1:0] hold_q;
    logic [HOLD_W-1:0] hold_d;
    logic              rd_pend0_q;
    logic              rd_pend1_q;
    logic              rd_pend0_d;
    logic              rd_pend1_d;
    logic              clken_q;
    logic [STALL_W-1:0] stall_q;
    logic [STALL_W-1:0] stall_d;

    assign req0     = m0_read | m0_write;
    assign req1     = m1_read | m1_write;
    assign hold_max = (hold_q == HOLD_W'(MAX_HOLD));

    // No command may reach the RAM while reset is asserted, so reset_n gates both grants.
    always_comb begin
        gnt1 = reset_n & req1 & ~(req0 & hold_max);
        gnt0 = reset_n & req0 & ~gnt1;
    end

    assign m0_waitrequest = req0 & ~gnt0;
    assign m1_waitrequest = req1 & ~gnt1;

    // Idle cycles leave the RAM bus following m0 with chipselect low.
    always_comb begin
        if (gnt1) begin
            mem_address    = m1_address;
            mem_byteenable = m1_byteenable;
            mem_writedata  = m1_writedata;
            mem_write      = m1_write;
        end else begin
            mem_address    = m0_address;
            mem_byteenable = m0_byteenable;
            mem_writedata  = m0_writedata;
            mem_write      = gnt0 & m0_write;
        end
        mem_chipselect = gnt0 | gnt1;
    end

    always_comb begin
        hold_d = hold_q;
        if (gnt1 && req0) begin
            hold_d = hold_q + HOLD_W'(1);
        end else if (gnt0 || !req0) begin
            hold_d = '0;
        end
    end

    // A simultaneous write wins over read, so such a command returns no data.
    assign rd_pend0_d = gnt0 & m0_read & ~m0_write;
    assign rd_pend1_d = gnt1 & m1_read & ~m1_write;

    always_comb begin
        stall_d = stall_q;
        if (req0 && !gnt0 && !(&stall_q)) begin
            stall_d = stall_q + STALL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_q     <= '0;
            rd_pend0_q <= 1'b0;
            rd_pend1_q <= 1'b0;
            clken_q    <= 1'b0;
            stall_q    <= '0;
        end else begin
            hold_q     <= hold_d;
            rd_pend0_q <= rd_pend0_d;
            rd_pend1_q <= rd_pend1_d;
            clken_q    <= 1'b1;
            stall_q    <= stall_d;
        end
    end

    assign mem_clken        = clken_q;
    assign m0_readdatavalid = rd_pend0_q;
    assign m1_readdatavalid = rd_pend1_q;
    assign m0_readdata      = rd_pend0_q ? mem_readdata : '0;
    assign m1_readdata      = rd_pend1_q ? mem_readdata : '0;
    assign m0_stall_count   = stall_q;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Directed bench for onchip_mem_arbiter with a behavioural 32K x 32 RAM (registered q,
// byte enables, gated by clken/chipselect).
module tb_onchip_mem_arbiter;

    logic        clk;
    logic        reset_n;
    logic [14:0] m0_address;
    logic        m0_read;
    logic        m0_write;
    logic [3:0]  m0_byteenable;
    logic [31:0] m0_writedata;
    logic        m0_waitrequest;
    logic [31:0] m0_readdata;
    logic        m0_readdatavalid;
    logic [14:0] m1_address;
    logic        m1_read;
    logic        m1_write;
    logic [3:0]  m1_byteenable;
    logic [31:0] m1_writedata;
    logic        m1_waitrequest;
    logic [31:0] m1_readdata;
    logic        m1_readdatavalid;
    logic [14:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic        mem_clken;
    logic [31:0] mem_readdata;
    logic [15:0] m0_stall_count;

    int checks = 0;
    int errors = 0;
    int g0;

    onchip_mem_arbiter dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .m0_address       (m0_address),
        .m0_read          (m0_read),
        .m0_write         (m0_write),
        .m0_byteenable    (m0_byteenable),
        .m0_writedata     (m0_writedata),
        .m0_waitrequest   (m0_waitrequest),
        .m0_readdata      (m0_readdata),
        .m0_readdatavalid (m0_readdatavalid),
        .m1_address       (m1_address),
        .m1_read          (m1_read),
        .m1_write         (m1_write),
        .m1_byteenable    (m1_byteenable),
        .m1_writedata     (m1_writedata),
        .m1_waitrequest   (m1_waitrequest),
        .m1_readdata      (m1_readdata),
        .m1_readdatavalid (m1_readdatavalid),
        .mem_address      (mem_address),
        .mem_byteenable   (mem_byteenable),
        .mem_chipselect   (mem_chipselect),
        .mem_write        (mem_write),
        .mem_writedata    (mem_writedata),
        .mem_clken        (mem_clken),
        .mem_readdata     (mem_readdata),
        .m0_stall_count   (m0_stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] ram [0:32767];
    always @(posedge clk) begin
        if (mem_clken && mem_chipselect) begin
            if (mem_write) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
                end
            end
            mem_readdata <= ram[mem_address];
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
    endtask

    initial begin
        reset_n = 0; mem_readdata = '0;
        idle();
        m0_address = '0; m0_byteenable = 4'hF; m0_writedata = '0;
        m1_address = '0; m1_byteenable = 4'hF; m1_writedata = '0;

        // Reset state, with m0 requesting while in reset
        repeat (2) step();
        m0_read = 1;
        @(negedge clk);
        chk("rst_wait0", m0_waitrequest, 1);
        chk("rst_cs", mem_chipselect, 0);
        chk("rst_clken", mem_clken, 0);
        chk("rst_rdv0", m0_readdatavalid, 0);
        chk("rst_rd0", m0_readdata, 0);
        chk("rst_stall", m0_stall_count, 0);
        m0_read = 0;
        reset_n = 1;
        step();
        @(negedge clk);
        chk("clken_up", mem_clken, 1);
        step();

        // 1: m0 write then read back
        m0_write = 1; m0_address = 15'h0010; m0_writedata = 32'hDEADBEEF; m0_byteenable = 4'hF;
        @(negedge clk);
        chk("t1_wr_wait", m0_waitrequest, 0);
        chk("t1_wr_memwr", mem_write, 1);
        chk("t1_wr_cs", mem_chipselect, 1);
        step();
        m0_write = 0; m0_read = 1;
        @(negedge clk);
        chk("t1_rd_wait", m0_waitrequest, 0);
        chk("t1_rd_memwr", mem_write, 0);
        chk("t1_rd_rdv_early", m0_readdatavalid, 0);
        step();
        m0_read = 0;
        @(negedge clk);
        chk("t1_rdv", m0_readdatavalid, 1);
        chk("t1_data", m0_readdata, 32'hDEADBEEF);
        chk("t1_rdv1", m1_readdatavalid, 0);
        chk("t1_rd1", m1_readdata, 0);
        chk("t1_idle_cs", mem_chipselect, 0);
        step();

        // 2: partial write at the top address
        m1_write = 1; m1_address = 15'h7FFF; m1_writedata = 32'hFFFFFFFF; m1_byteenable = 4'hF;
        @(negedge clk);
        chk("t2_fill_wait", m1_waitrequest, 0);
        step();
        m1_writedata = 32'h0000A5A5; m1_byteenable = 4'b0011;
        @(negedge clk);
        chk("t2_be", mem_byteenable, 4'b0011);
        chk("t2_memwr", mem_write, 1);
        step();
        m1_write = 0; m0_read = 1; m0_address = 15'h7FFF;
        @(negedge clk);
        chk("t2_addr", mem_address, 15'h7FFF);
        chk("t2_wait0", m0_waitrequest, 0);
        step();
        m0_read = 0;
        @(negedge clk);
        chk("t2_rdv", m0_readdatavalid, 1);
        chk("t2_data", m0_readdata, 32'hFFFFA5A5);
        step();

        // 3: continuous contention, MAX_HOLD = 4
        m0_read = 1; m0_address = 15'h0010; m1_read = 1; m1_address = 15'h7FFF;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk($sformatf("t3_wait0_%0d", k), m0_waitrequest, (k % 5) != 4);
            chk($sformatf("t3_wait1_%0d", k), m1_waitrequest, (k % 5) == 4);
            step();
        end
        idle();
        @(negedge clk);
        chk("t3_stall", m0_stall_count, 8);
        step();
        step();

        // 4: same-cycle reads, m1 served first
        m0_write = 1; m0_address = 15'h0100; m0_writedata = 32'h11111111; m0_byteenable = 4'hF;
        step();
        m0_write = 0;
        m1_write = 1; m1_address = 15'h0200; m1_writedata = 32'h22222222; m1_byteenable = 4'hF;
        step();
        m1_write = 0;
        m0_read = 1; m1_read = 1;
        @(negedge clk);
        chk("t4_T_wait1", m1_waitrequest, 0);
        chk("t4_T_wait0", m0_waitrequest, 1);
        chk("t4_T_addr", mem_address, 15'h0200);
        step();
        m1_read = 0;
        @(negedge clk);
        chk("t4_T1_rdv1", m1_readdatavalid, 1);
        chk("t4_T1_data1", m1_readdata, 32'h22222222);
        chk("t4_T1_rdv0", m0_readdatavalid, 0);
        chk("t4_T1_rd0", m0_readdata, 0);
        chk("t4_T1_wait0", m0_waitrequest, 0);
        chk("t4_T1_addr", mem_address, 15'h0100);
        step();
        m0_read = 0;
        @(negedge clk);
        chk("t4_T2_rdv0", m0_readdatavalid, 1);
        chk("t4_T2_data0", m0_readdata, 32'h11111111);
        chk("t4_T2_rdv1", m1_readdatavalid, 0);
        chk("t4_T2_rd1", m1_readdata, 0);
        chk("t4_stall", m0_stall_count, 9);
        step();

        // 5: reset asserted during an m1 read
        m1_read = 1; m1_address = 15'h0200;
        #2 reset_n = 0;
        @(negedge clk);
        chk("t5_wait1", m1_waitrequest, 1);
        chk("t5_cs", mem_chipselect, 0);
        step();
        m1_read = 0;
        @(negedge clk);
        chk("t5_rdv1", m1_readdatavalid, 0);
        chk("t5_rd1", m1_readdata, 0);
        chk("t5_rdv0", m0_readdatavalid, 0);
        chk("t5_stall", m0_stall_count, 0);
        chk("t5_clken", mem_clken, 0);
        reset_n = 1;
        step();
        @(negedge clk);
        chk("t5_clken_up", mem_clken, 1);
        step();
        m1_read = 1;
        @(negedge clk);
        chk("t5_post_wait1", m1_waitrequest, 0);
        step();
        m1_read = 0;
        @(negedge clk);
        chk("t5_post_rdv1", m1_readdatavalid, 1);
        chk("t5_post_data1", m1_readdata, 32'h22222222);
        step();

        // 6: stall counter saturation (65600 stalled cycles over 82000)
        g0 = 0;
        m0_read = 1; m0_address = 15'h0010; m1_read = 1; m1_address = 15'h7FFF;
        for (int k = 0; k < 82000; k++) begin
            @(negedge clk);
            if (!m0_waitrequest) g0++;
            step();
        end
        idle();
        @(negedge clk);
        chk("t6_m0_grants", g0, 16400);
        chk("t6_stall_sat", m0_stall_count, 16'hFFFF);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
